// File: rtl/reverse_stream_ctrl_if.sv
// Stream-in, stream-out and counter-command bundle for reverse_stream_ctrl.
// The slave modport is the controller's view; master is the surrounding fabric.
interface reverse_stream_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    logic              cnt_up;
    logic              cnt_down;
    logic              cnt_clr;
    logic [4:0]        cnt_value;
    logic              cnt_zero;

    modport slave (
        input  in_valid, in_data, in_last, out_ready, cnt_value, cnt_zero,
        output in_ready, out_valid, out_data, out_last, cnt_up, cnt_down, cnt_clr
    );

    modport master (
        output in_valid, in_data, in_last, out_ready, cnt_value, cnt_zero,
        input  in_ready, out_valid, out_data, out_last, cnt_up, cnt_down, cnt_clr
    );
endinterface

// File: rtl/reverse_stream_ctrl.sv
// LIFO frame buffer: stores a frame at the external counter's value, then replays it
// in reverse while commanding the counter down to zero.
module reverse_stream_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    output logic                  busy,
    reverse_stream_ctrl_if.slave  bus
);
    localparam int         DEPTH     = 31;
    localparam logic [4:0] CNT_FULL  = 5'd31;
    localparam logic [4:0] CNT_FINAL = 5'd30;
    localparam logic [4:0] CNT_ONE   = 5'd1;

    localparam logic [0:0] FILL  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [0:0]        state_q;
    logic [0:0]        state_d;
    logic [DATA_W-1:0] mem_q [0:DEPTH-1];
    logic [4:0]        rd_addr;

    logic in_ready_d;
    logic out_valid_d;
    logic cnt_up_d;
    logic cnt_down_d;
    logic cnt_clr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // The counter value is the write pointer; cnt_up_d doubles as the write strobe.
    always_ff @(posedge clk) begin
        if (cnt_up_d) begin
            mem_q[bus.cnt_value] <= bus.in_data;
        end
    end

    // Wraps to 31 at count zero, but the read is only presented when the count is non-zero.
    assign rd_addr = bus.cnt_value - CNT_ONE;

    always_comb begin
        state_d     = state_q;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        cnt_up_d    = 1'b0;
        cnt_down_d  = 1'b0;
        cnt_clr_d   = 1'b0;
        if (rst) begin
            state_d = FILL;
        end else if (flush) begin
            cnt_clr_d = 1'b1;
            state_d   = FILL;
        end else if (state_q == FILL) begin
            in_ready_d = (bus.cnt_value != CNT_FULL);
            if (bus.in_valid && in_ready_d) begin
                cnt_up_d = 1'b1;
                if (bus.in_last || (bus.cnt_value == CNT_FINAL)) begin
                    state_d = DRAIN;
                end
            end
        end else if (bus.cnt_zero) begin
            state_d = FILL;
        end else begin
            out_valid_d = 1'b1;
            if (bus.out_ready) begin
                cnt_down_d = 1'b1;
                if (bus.cnt_value == CNT_ONE) begin
                    state_d = FILL;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_d;
    assign bus.out_valid = out_valid_d;
    assign bus.out_data  = mem_q[rd_addr];
    assign bus.out_last  = (state_q == DRAIN) && (bus.cnt_value == CNT_ONE);
    assign bus.cnt_up    = cnt_up_d;
    assign bus.cnt_down  = cnt_down_d;
    assign bus.cnt_clr   = cnt_clr_d;
    assign busy          = (state_q != FILL) || (bus.cnt_value != 5'd0);
endmodule

// File: tb/tb_reverse_stream_ctrl.sv
// Randomized bench for reverse_stream_ctrl with a behavioural counter, a LIFO reference
// model checked every cycle, and a scoreboard for the replayed words.
module tb_reverse_stream_ctrl;
    localparam int DATA_W = 8;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic flush = 1'b0;
    logic busy;

    int checks   = 0;
    int failures = 0;

    reverse_stream_ctrl_if #(.DATA_W(DATA_W)) bus ();

    reverse_stream_ctrl #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural 5-bit up/down counter wired beside the controller.
    logic [4:0] cnt_q;
    always @(posedge clk) begin
        if (rst)               cnt_q <= 5'd0;
        else if (bus.cnt_clr)  cnt_q <= 5'd0;
        else if (bus.cnt_up)   cnt_q <= cnt_q + 5'd1;
        else if (bus.cnt_down) cnt_q <= cnt_q - 5'd1;
    end
    assign bus.cnt_value = cnt_q;
    assign bus.cnt_zero  = (cnt_q == 5'd0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a stack of stored words and a replaying flag.
    logic [DATA_W-1:0] stack[$];
    bit                draining = 1'b0;
    logic [DATA_W:0]   exp_q[$];

    always @(posedge clk) begin
        if (rst || flush) begin
            stack.delete();
            exp_q.delete();
            draining = 1'b0;
        end else if (!draining) begin
            if (bus.in_valid && stack.size() < 31) begin
                stack.push_back(bus.in_data);
                if (bus.in_last || stack.size() == 31) begin
                    draining = 1'b1;
                    for (int i = stack.size() - 1; i >= 0; i--)
                        exp_q.push_back({(i == 0), stack[i]});
                end
            end
        end else if (bus.out_ready && stack.size() != 0) begin
            void'(stack.pop_back());
            if (stack.size() == 0) draining = 1'b0;
        end
    end

    // Per-cycle flow checks and scoreboard pops, sampled mid-cycle.
    always @(negedge clk) begin : monitor
        int sz;
        bit exp_ir;
        bit exp_ov;
        logic [DATA_W:0] exp_word;
        if (!rst) begin
            sz     = stack.size();
            exp_ir = !flush && !draining && sz < 31;
            exp_ov = draining && !flush && sz != 0;
            chk("in_ready",  32'(bus.in_ready),  32'(exp_ir));
            chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
            chk("out_last",  32'(bus.out_last),  32'(draining && sz == 1));
            chk("cnt_up",    32'(bus.cnt_up),    32'(exp_ir && bus.in_valid));
            chk("cnt_down",  32'(bus.cnt_down),  32'(exp_ov && bus.out_ready));
            chk("cnt_clr",   32'(bus.cnt_clr),   32'(flush));
            chk("busy",      32'(busy),          32'(draining || sz != 0));
            chk("cnt_value", 32'(bus.cnt_value), 32'(sz));
            if (exp_ov) chk("out_data_top", 32'(bus.out_data), 32'(stack[sz-1]));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty", 32'(1), 32'(0));
                end else begin
                    exp_word = exp_q.pop_front();
                    chk("sb_data", 32'(bus.out_data), 32'(exp_word[DATA_W-1:0]));
                    chk("sb_last", 32'(bus.out_last), 32'(exp_word[DATA_W]));
                end
            end
        end
    end

    logic [DATA_W-1:0] tx_words[$];

    task automatic fill(input int gap_pct, input bit mark_last);
        int n = tx_words.size();
        bit got;
        int t;
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(99) < gap_pct) begin
                bus.in_valid = 1'b0;
                bus.in_last  = 1'b0;
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = tx_words[i];
            bus.in_last  = mark_last && (i == n - 1);
            got = 1'b0;
            t   = 0;
            while (!got && t < 200) begin
                @(negedge clk);
                got = bus.in_ready;
                @(posedge clk); #1;
                t++;
            end
            if (!got) begin
                chk("fill_timeout", 32'(0), 32'(1));
                break;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
    task automatic drain(input int mode);
        bit done = 1'b0;
        int t    = 0;
        while (!done && t < 400) begin
            case (mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (t % 4 == 0) || (t % 4 == 3);
                default: bus.out_ready = 1'($urandom_range(1));
            endcase
            @(negedge clk);
            done = bus.out_valid && bus.out_ready && bus.out_last;
            @(posedge clk); #1;
            t++;
        end
        if (!done) chk("drain_timeout", 32'(0), 32'(1));
        bus.out_ready = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        int n;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Three-word frame, back to back, consumer always ready.
        bus.out_ready = 1'b1;
        tx_words = '{8'hA1, 8'hA2, 8'hA3};
        fill(0, 1'b1);
        drain(0);

        // 31 words without in_last: frame force-closes.
        tx_words.delete();
        for (int i = 0; i < 31; i++) tx_words.push_back(8'(i));
        fill(0, 1'b0);
        drain(0);

        // Single-word frame.
        tx_words = '{8'h5A};
        fill(0, 1'b1);
        drain(0);

        // Stalling consumer.
        tx_words = '{8'h11, 8'h22, 8'h33, 8'h44};
        fill(0, 1'b1);
        drain(1);

        // Flush after one of three words has been replayed.
        tx_words = '{8'hC1, 8'hC2, 8'hC3};
        bus.out_ready = 1'b1;
        fill(0, 1'b1);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset with five words stored, then a fresh two-word frame.
        tx_words = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        fill(0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tx_words = '{8'hE1, 8'hE2};
        fill(0, 1'b1);
        drain(2);

        // Random frames with producer gaps and a random consumer.
        repeat (40) begin
            n = $urandom_range(31, 1);
            tx_words.delete();
            for (int i = 0; i < n; i++) tx_words.push_back(8'($urandom));
            fill(20, (n < 31) ? 1'b1 : 1'($urandom_range(1)));
            drain(2);
        end

        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reverse_stream_ctrl.md
# reverse_stream_ctrl

Controller and storage that drives the team's 5-bit up/down counter from the other side of its count interface. It issues count-up, count-down and clear commands and consumes the counter's value and zero flag. It accepts a frame of up to 31 words on a valid/ready input stream and stores each word at the current count. It then replays the frame in reverse (LIFO) order on a valid/ready output stream, counting down until the counter reports zero. It sits between a producer and a consumer, and the counter instance is wired beside it.

## Interface
- DATA_W, 8, width of stream data words
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset; same reset also drives the counter instance
- flush  in  1  synchronous abort of current frame
- in_valid  in  1  producer has a word
- in_ready  out  1  block accepts a word this cycle
- in_data  in  DATA_W  input word
- in_last  in  1  word is last of frame
- out_valid  out  1  block presents a word
- out_ready  in  1  consumer takes word this cycle
- out_data  out  DATA_W  output word
- out_last  out  1  presented word is last (was first written)
- cnt_up  out  1  counter increment command
- cnt_down  out  1  counter decrement command
- cnt_clr  out  1  counter synchronous clear command
- cnt_value  in  5  counter value
- cnt_zero  in  1  counter value == 0
- busy  out  1  frame stored or draining (state != FILL or cnt_value != 0)

## Operation
- Storage: 31 × DATA_W register array, addresses 0..30; no reset on contents.
- FSM states: FILL (reset state), DRAIN.
- FILL:
  - in_ready = ~flush & (cnt_value != 31).
  - Accept = in_valid & in_ready: write mem[cnt_value] <= in_data, assert cnt_up.
  - Go to DRAIN when the accepted word has in_last = 1, or when cnt_value == 30 at accept (31st word; frame force-closed).
  - out_valid = 0.
- DRAIN:
  - in_ready = 0.
  - out_valid = ~cnt_zero & ~flush.
  - out_data = mem[cnt_value − 1], combinational from the array.
  - out_last = (cnt_value == 1).
  - Handshake = out_valid & out_ready: assert cnt_down.
  - Handshake with out_last goes to FILL.
  - cnt_zero seen in DRAIN (defensive) goes to FILL without output.
- flush (either state): cnt_clr = 1, cnt_up = cnt_down = 0, no handshake completes, next state FILL. Stored data is abandoned.
- cnt_up and cnt_down are mutually exclusive and never asserted together with cnt_clr.
- cnt_up is never issued at cnt_value 31, and cnt_down is never issued at 0, so the counter never wraps.
- Width rule: cnt_value − 1 is taken modulo 32 and is used only when cnt_zero = 0.
- rst has priority over flush. Reset mid-FILL or mid-DRAIN returns to FILL, all command outputs 0, and the frame is lost.

## Timing
- Reset values (cycle after rst, counter at 0): state FILL, in_ready 1, out_valid 0, out_last 0, cnt_up/cnt_down/cnt_clr 0, busy 0.
- All command outputs are combinational from state, the handshakes and flush. The counter updates at the next edge.
- Write at edge N makes the word readable at N+1. The last accepted word appears on out_data in cycle N+1, so fill-to-drain latency is 1 cycle.
- Full throughput: one word per cycle in both phases while valid/ready hold.
- Frame boundary: the cycle after the final output handshake has in_ready = 1. There are no dead cycles other than the single phase turnaround.
- out_data/out_last are held stable while out_valid = 1 and out_ready = 0.

## Test plan
- Reset, then push A1,A2,A3 (A3 in_last) back-to-back with out_ready = 1:
  - cycle after A3, out_valid = 1 with A3.
  - then A2, then A1 with out_last = 1.
  - next cycle in_ready = 1 and cnt_value = 0.
- Push 31 words 0x00..0x1E with in_last = 0:
  - in_ready drops after the 31st word and DRAIN is entered.
  - output runs 0x1E down to 0x00, with out_last on 0x00.
  - no cnt_up is issued at cnt_value 31.
- Single-word frame 0x5A with in_last: next cycle out_valid = 1, out_data = 0x5A, out_last = 1.
- Drain with out_ready toggling 1,0,0,1: out_data is stable while stalled, and cnt_down is asserted only on cycles with out_ready = 1.
- flush mid-DRAIN after one of three words is popped:
  - cnt_clr pulses for one cycle.
  - out_valid is 0 that cycle.
  - next cycle FILL, in_ready = 1, busy = 0.
- rst asserted during FILL with 5 words stored: next cycle state FILL, cnt_value 0, out_valid 0, and a new 2-word frame replays correctly.
